// File: rtl/keypad_input.sv
// Keypad front end: per-key 2-flop synchroniser, debounce FSM and counter,
// KEYINPUT presentation, and KEYCNT interrupt evaluation with a one-cycle IRQ pulse.
module keypad_input #(
   parameter int NKEYS           = 10,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 19
) (
   input  logic             clk_50mhz,
   input  logic             rstn,
   input  logic [NKEYS-1:0] keys_n,
   input  logic [15:0]      keycnt,
   output logic [15:0]      keyinput,
   output logic [NKEYS-1:0] key_event,
   output logic             irq
);

   typedef enum logic {
      ST_STABLE   = 1'b0,
      ST_SETTLING = 1'b1
   } deb_state_e;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [NKEYS-1:0] sync1_q, sync2_q;
   logic [NKEYS-1:0] deb_q, deb_d;
   logic [NKEYS-1:0] key_event_q, key_event_d;
   deb_state_e       state_q [NKEYS];
   deb_state_e       state_d [NKEYS];
   logic [CNT_W-1:0] cnt_q   [NKEYS];
   logic [CNT_W-1:0] cnt_d   [NKEYS];

   logic [NKEYS-1:0] sel, pr;
   logic             cond, act;
   logic             cond_q;
   logic             irq_q, irq_d;
   logic             keycnt_unused;

   // A mismatch must persist for DEBOUNCE_CYCLES consecutive clocks before it is accepted.
   always_comb begin
      deb_d       = deb_q;
      key_event_d = '0;
      state_d     = state_q;
      cnt_d       = cnt_q;
      for (int i = 0; i < NKEYS; i++) begin
         case (state_q[i])
            ST_STABLE: begin
               if (sync2_q[i] != deb_q[i]) begin
                  state_d[i] = ST_SETTLING;
                  cnt_d[i]   = CNT_ONE;
               end else begin
                  cnt_d[i] = '0;
               end
            end
            ST_SETTLING: begin
               if (sync2_q[i] == deb_q[i]) begin
                  state_d[i] = ST_STABLE;
                  cnt_d[i]   = '0;
               end else if (cnt_q[i] == CNT_LAST) begin
                  deb_d[i]       = sync2_q[i];
                  key_event_d[i] = 1'b1;
                  state_d[i]     = ST_STABLE;
                  cnt_d[i]       = '0;
               end else begin
                  cnt_d[i] = cnt_q[i] + CNT_ONE;
               end
            end
            default: begin
               state_d[i] = ST_STABLE;
               cnt_d[i]   = '0;
            end
         endcase
      end
   end

   // An empty select never asserts the condition, in either mode.
   always_comb begin
      sel   = keycnt[NKEYS-1:0];
      pr    = ~deb_q & sel;
      cond  = keycnt[15] ? ((pr == sel) && (sel != '0)) : (|pr);
      act   = cond & keycnt[14];
      irq_d = act & ~cond_q;
   end

   always_ff @(posedge clk_50mhz or negedge rstn) begin
      if (!rstn) begin
         sync1_q     <= '1;
         sync2_q     <= '1;
         deb_q       <= '1;
         key_event_q <= '0;
         cond_q      <= 1'b0;
         irq_q       <= 1'b0;
         for (int i = 0; i < NKEYS; i++) begin
            state_q[i] <= ST_STABLE;
            cnt_q[i]   <= '0;
         end
      end else begin
         sync1_q     <= keys_n;
         sync2_q     <= sync1_q;
         deb_q       <= deb_d;
         key_event_q <= key_event_d;
         cond_q      <= act;
         irq_q       <= irq_d;
         for (int i = 0; i < NKEYS; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
      end
   end

   assign keycnt_unused = ^keycnt[13:NKEYS];
   assign keyinput      = {{(16-NKEYS){1'b0}}, deb_q};
   assign key_event     = key_event_q;
   assign irq           = irq_q;

endmodule

// File: tb/tb_keypad_input.sv
// Bench for keypad_input with a short debounce window: directed scenarios plus a
// randomized run, all compared against a run-length reference model of the key rules.
module tb_keypad_input;

   localparam int D = 8;

   logic        clk_50mhz = 1'b0;
   logic        rstn      = 1'b0;
   logic [9:0]  keys_n    = 10'h3FF;
   logic [15:0] keycnt    = 16'h0000;
   logic [15:0] keyinput;
   logic [9:0]  key_event;
   logic        irq;

   int chk  = 0;
   int pass = 0;

   keypad_input #(.NKEYS(10), .DEBOUNCE_CYCLES(D), .CNT_W(4)) dut (
      .clk_50mhz (clk_50mhz),
      .rstn      (rstn),
      .keys_n    (keys_n),
      .keycnt    (keycnt),
      .keyinput  (keyinput),
      .key_event (key_event),
      .irq       (irq)
   );

   always #10 clk_50mhz = ~clk_50mhz;

   // Reference: a key is accepted once its synchronised level has disagreed with the
   // accepted level for D consecutive clocks; irq fires on the rising edge of the enabled condition.
   logic [9:0] m_s1, m_s2, m_deb, m_ev;
   logic       m_actp, m_irq;
   int         m_run [10];

   function automatic logic irq_cond(input logic [9:0] deb, input logic [15:0] kc);
      int nsel = 0;
      int npr  = 0;
      for (int i = 0; i < 10; i++) begin
         if (kc[i]) begin
            nsel++;
            if (!deb[i]) npr++;
         end
      end
      if (!kc[14]) return 1'b0;
      if (kc[15]) return (nsel > 0) && (npr == nsel);
      return npr > 0;
   endfunction

   always @(posedge clk_50mhz or negedge rstn) begin : model
      logic [9:0] nd;
      logic [9:0] ne;
      logic       a;
      if (!rstn) begin
         m_s1   <= '1;
         m_s2   <= '1;
         m_deb  <= '1;
         m_ev   <= '0;
         m_actp <= 1'b0;
         m_irq  <= 1'b0;
         for (int i = 0; i < 10; i++) m_run[i] <= 0;
      end else begin
         nd = m_deb;
         ne = '0;
         for (int i = 0; i < 10; i++) begin
            if (m_s2[i] !== m_deb[i]) begin
               if (m_run[i] + 1 == D) begin
                  nd[i] = m_s2[i];
                  ne[i] = 1'b1;
                  m_run[i] <= 0;
               end else begin
                  m_run[i] <= m_run[i] + 1;
               end
            end else begin
               m_run[i] <= 0;
            end
         end
         a = irq_cond(m_deb, keycnt);
         m_irq  <= a && !m_actp;
         m_actp <= a;
         m_deb  <= nd;
         m_ev   <= ne;
         m_s2   <= m_s1;
         m_s1   <= keys_n;
      end
   end

   task automatic settle(input int n);
      repeat (n) @(negedge clk_50mhz);
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      settle(3);
      chk++;
      if ({keyinput, key_event, irq} !== {16'h03FF, 10'h000, 1'b0})
         $display("FAIL reset_hold: got %h/%h/%b want 03ff/000/0", keyinput, key_event, irq);
      else pass++;
      rstn = 1'b1;
      for (int n = 1; n <= 50; n++) begin
         @(negedge clk_50mhz);
         chk++;
         if ({keyinput, key_event, irq} !== {16'h03FF, 10'h000, 1'b0})
            $display("FAIL reset_idle cyc %0d: got %h/%h/%b want 03ff/000/0", n, keyinput, key_event, irq);
         else pass++;
      end
   endtask

   task automatic test_press_latency();
      logic [15:0] eki;
      logic [9:0]  eev;
      keys_n = 10'h3FE;
      for (int n = 1; n <= 14; n++) begin
         @(negedge clk_50mhz);
         eki = (n >= 10) ? 16'h03FE : 16'h03FF;
         eev = (n == 10) ? 10'h001 : 10'h000;
         chk++;
         if ({keyinput, key_event, irq} !== {eki, eev, 1'b0})
            $display("FAIL press_latency cyc %0d: got %h/%h/%b want %h/%h/0", n, keyinput, key_event, irq, eki, eev);
         else pass++;
         chk++;
         if ({keyinput, key_event, irq} !== {6'b0, m_deb, m_ev, m_irq})
            $display("FAIL press_model cyc %0d: got %h/%h/%b want %h/%h/%b", n, keyinput, key_event, irq, m_deb, m_ev, m_irq);
         else pass++;
      end
      keys_n = 10'h3FF;
      settle(14);
   endtask

   task automatic test_glitch();
      logic [15:0] eki;
      keys_n = 10'h3FD;
      for (int n = 1; n <= 25; n++) begin
         @(negedge clk_50mhz);
         if (n == 5) keys_n = 10'h3FF;
         chk++;
         if ({keyinput, key_event, irq} !== {16'h03FF, 10'h000, 1'b0})
            $display("FAIL glitch cyc %0d: got %h/%h/%b want 03ff/000/0", n, keyinput, key_event, irq);
         else pass++;
      end
      // A fresh press must take the full window again.
      keys_n = 10'h3FD;
      for (int n = 1; n <= 12; n++) begin
         @(negedge clk_50mhz);
         eki = (n >= 10) ? 16'h03FD : 16'h03FF;
         chk++;
         if (keyinput !== eki)
            $display("FAIL glitch_repress cyc %0d: got %h want %h", n, keyinput, eki);
         else pass++;
      end
      keys_n = 10'h3FF;
      settle(14);
   endtask

   task automatic test_or_irq();
      keycnt = 16'h4003;
      keys_n = 10'h3FD;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk_50mhz);
         chk++;
         if (irq !== (n == 11))
            $display("FAIL or_irq cyc %0d: got %b want %b (keyinput %h)", n, irq, (n == 11), keyinput);
         else pass++;
      end
      keys_n = 10'h3FC;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk_50mhz);
         chk++;
         if (irq !== 1'b0)
            $display("FAIL or_second_key cyc %0d: got %b want 0", n, irq);
         else pass++;
      end
      chk++;
      if (keyinput !== 16'h03FC)
         $display("FAIL or_keyinput: got %h want 03fc", keyinput);
      else pass++;
      keycnt = 16'h0000;
      keys_n = 10'h3FF;
      settle(14);
   endtask

   task automatic test_and_irq();
      int pulses;
      keycnt = 16'hC003;
      keys_n = 10'h3FE;
      pulses = 0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk_50mhz);
         if (irq === 1'b1) pulses++;
      end
      chk++;
      if (pulses !== 0) $display("FAIL and_a_only: got %0d pulses want 0", pulses);
      else pass++;
      for (int r = 0; r < 2; r++) begin
         keys_n = 10'h3FC;
         pulses = 0;
         for (int n = 1; n <= 20; n++) begin
            @(negedge clk_50mhz);
            if (irq === 1'b1) pulses++;
            chk++;
            if (irq !== (n == 11))
               $display("FAIL and_press_b round %0d cyc %0d: got %b want %b", r, n, irq, (n == 11));
            else pass++;
         end
         chk++;
         if (pulses !== 1) $display("FAIL and_pulse_count round %0d: got %0d want 1", r, pulses);
         else pass++;
         keys_n = 10'h3FE;
         pulses = 0;
         for (int n = 1; n <= 20; n++) begin
            @(negedge clk_50mhz);
            if (irq === 1'b1) pulses++;
         end
         chk++;
         if (pulses !== 0) $display("FAIL and_release_b round %0d: got %0d pulses want 0", r, pulses);
         else pass++;
      end
      keycnt = 16'h0000;
      keys_n = 10'h3FF;
      settle(14);
   endtask

   task automatic test_enable_write();
      keys_n = 10'h3FE;
      settle(15);
      keycnt = 16'h4001;
      for (int n = 1; n <= 5; n++) begin
         @(negedge clk_50mhz);
         chk++;
         if (irq !== (n == 1))
            $display("FAIL enable_write cyc %0d: got %b want %b", n, irq, (n == 1));
         else pass++;
      end
      keycnt = 16'h4000;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk_50mhz);
         chk++;
         if (irq !== 1'b0)
            $display("FAIL empty_select cyc %0d: got %b want 0", n, irq);
         else pass++;
      end
      keycnt = 16'h0000;
      keys_n = 10'h3FF;
      settle(14);
   endtask

   task automatic test_reset_mid_settle();
      logic [15:0] eki;
      keys_n = 10'h3FB;
      settle(5);
      rstn = 1'b0;
      #1;
      chk++;
      if ({keyinput, key_event, irq} !== {16'h03FF, 10'h000, 1'b0})
         $display("FAIL reset_mid: got %h/%h/%b want 03ff/000/0", keyinput, key_event, irq);
      else pass++;
      @(negedge clk_50mhz);
      rstn = 1'b1;
      for (int n = 1; n <= 14; n++) begin
         @(negedge clk_50mhz);
         eki = (n >= 10) ? 16'h03FB : 16'h03FF;
         chk++;
         if (keyinput !== eki)
            $display("FAIL reset_restart cyc %0d: got %h want %h", n, keyinput, eki);
         else pass++;
      end
      // Reset must also drop an already accepted press.
      rstn = 1'b0;
      #1;
      chk++;
      if (keyinput !== 16'h03FF)
         $display("FAIL reset_debounced: got %h want 03ff", keyinput);
      else pass++;
      @(negedge clk_50mhz);
      rstn = 1'b1;
      keys_n = 10'h3FF;
      settle(14);
   endtask

   task automatic test_random();
      int hold [10];
      int pulses;
      pulses = 0;
      for (int i = 0; i < 10; i++) hold[i] = $urandom_range(1, 30);
      for (int n = 1; n <= 3000; n++) begin
         @(negedge clk_50mhz);
         chk++;
         if ({keyinput, key_event, irq} !== {6'b0, m_deb, m_ev, m_irq})
            $display("FAIL random cyc %0d: got %h/%h/%b want %h/%h/%b", n, keyinput, key_event, irq, m_deb, m_ev, m_irq);
         else pass++;
         if (irq === 1'b1) pulses++;
         for (int i = 0; i < 10; i++) begin
            hold[i]--;
            if (hold[i] <= 0) begin
               keys_n[i] = ~keys_n[i];
               hold[i] = $urandom_range(1, 30);
            end
         end
         if ($urandom_range(0, 40) == 0) begin
            keycnt = '0;
            keycnt[15] = 1'($urandom_range(0, 1));
            keycnt[14] = ($urandom_range(0, 3) != 0);
            keycnt[$urandom_range(0, 9)] = 1'b1;
            if ($urandom_range(0, 1) == 1) keycnt[$urandom_range(0, 9)] = 1'b1;
         end
      end
      keys_n = 10'h3FF;
      keycnt = 16'h0000;
      settle(14);
      chk++;
      if (keyinput !== 16'h03FF)
         $display("FAIL random_final: got %h want 03ff (irq pulses %0d)", keyinput, pulses);
      else pass++;
   endtask

   initial begin
      test_reset();
      test_press_latency();
      test_glitch();
      test_or_irq();
      test_and_irq();
      test_enable_write();
      test_reset_mid_settle();
      test_random();
      $display("%0d/%0d checks passed", pass, chk);
      $finish;
   end

endmodule
